ps2_key_tracker: RTL
====================

Name: ps2_key_tracker

Overview:
Per-byte PS/2 scancode sequencer between the PS2_Controller byte stream (received_data / received_data_en) and the game movement logic. Parses set-2 multi-byte sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) with a prefix-timeout FSM. Maintains held/released state for the four arrow keys and the space bar, and drives a registered movement vector plus fire level.

Parameters:
TIMEOUT_CYCLES, 2500000, clock cycles allowed between bytes of a multi-byte sequence before the FSM abandons it (50 ms at 50 MHz).
PAUSE_TAIL, 7, bytes following E1 that are discarded as the Pause sequence.

Ports:
clock  input  1  system clock (CLOCK_50 domain).
reset  input  1  asynchronous, active-high reset.
key_data  input  8  received byte from PS2_Controller; valid only while key_pressed=1.
key_pressed  input  1  one-cycle strobe, one per received byte.
movement  output  4  held-direction vector: bit0 up, bit1 down, bit2 left, bit3 right; opposing pairs masked.
fire  output  1  space bar held.
key_event  output  1  one-cycle pulse when any tracked key changes held state.
seq_timeout  output  1  one-cycle pulse when a partial sequence is abandoned on timeout.

Behaviour:
- Reset (async, any time incl. mid-sequence): FSM=IDLE, all held bits=0, movement=0, fire=0, key_event=0, seq_timeout=0, timeout counter=0, skip counter=0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (inside Pause tail).
- Transitions, evaluated only on cycles with key_pressed=1:
  - IDLE: E0->EXT; F0->BRK; E1->SKIP with skip counter=PAUSE_TAIL; 29->set space held; FA, AA, EE, FE, 00, FF ignored; any other code ignored; otherwise stay IDLE.
  - EXT: F0->EXT_BRK. 75/72/6B/74 set up/down/left/right held, ->IDLE. Any other byte ignored, ->IDLE. This covers fake-shift E0 12 / E0 59.
  - BRK: 29 clears space held; any byte ->IDLE.
  - EXT_BRK: 75/72/6B/74 clear the matching held bit; any byte ->IDLE.
  - SKIP: decrement skip counter on each byte; ->IDLE on the byte that reaches 0. No held state changes.
- Timeout: counter clears on every key_pressed and increments each cycle while FSM is not IDLE. It saturates at TIMEOUT_CYCLES-1; on the cycle it would reach TIMEOUT_CYCLES the FSM goes to IDLE and seq_timeout pulses. Held bits are untouched. A key_pressed arriving on that same cycle wins: the byte is processed normally and there is no timeout pulse.
- Repeat make codes (typematic) for an already-held key cause no change and no key_event.
- Output timing: held bits update on the clock edge that samples the final byte (key_pressed=1). movement, fire and key_event are registered from the held bits, giving 2 cycles from the final-byte strobe to a visible output change.
- Masking: movement[1:0]=00 when up and down are both held, else {down,up}; movement[3:2] is the same rule for left/right. Raw held bits are retained, so releasing one key of a pair exposes the other.
- key_event: high for exactly 1 cycle, aligned with the output change, when any of the 5 raw held bits differs from its previous value.
- key_pressed=0: key_data is ignored entirely.

Test Plan:
- Reset, then bytes E0,75 on consecutive strobes -> movement=0001 exactly 2 cycles after the 75 strobe; key_event 1-cycle pulse. Then E0,F0,75 -> movement=0000, second key_event.
- Hold up (E0 75), then hold down (E0 72) -> movement=0000. Release up (E0 F0 75) -> movement=0010.
- Bytes 29, 29, 29 (typematic), then F0 29 -> fire rises once with a single key_event, then falls with a single key_event. Non-extended 75 alone -> no change.
- E0 then no byte for TIMEOUT_CYCLES (TIMEOUT_CYCLES=16 in bench) -> seq_timeout pulse at cycle 16 and FSM back in IDLE. Following 75 -> movement unchanged.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> no output change, FSM IDLE after the 8th byte. Next E0 74 -> movement=1000.
- Assert reset mid-sequence after E0 F0 with left held -> movement=0000 immediately (async). After deassertion, byte 6B -> no change (FSM was reset to IDLE).

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns the PS/2 set-2 byte stream into held-key state for the four arrow
//   keys and the space bar. Multi-byte sequences (E0 extended, F0 break,
//   E1 Pause) are parsed by a small FSM. A partial sequence that stalls for
//   TIMEOUT_CYCLES is abandoned.
//
// Ports
//   clock       : system clock
//   reset       : asynchronous, active-high reset
//   key_data    : received byte, qualified by key_pressed
//   key_pressed : one-cycle strobe per received byte
//   movement    : {right,left,down,up} held vector; opposing pairs masked to 0
//   fire        : space bar held
//   key_event   : one-cycle pulse when any tracked held bit changes
//   seq_timeout : one-cycle pulse when a partial sequence is abandoned
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int PAUSE_TAIL     = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] key_data,
  input  logic       key_pressed,
  output logic [3:0] movement,
  output logic       fire,
  output logic       key_event,
  output logic       seq_timeout
);

  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SKIP_W = $clog2(PAUSE_TAIL + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(PAUSE_TAIL);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP
  } state_t;

  // held bit order: 0 up, 1 down, 2 left, 3 right, 4 space
  state_t            state_q, state_d;
  logic [4:0]        held_q, held_d;
  logic [4:0]        held_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              seq_timeout_q, seq_timeout_d;
  logic [3:0]        movement_q, movement_d;
  logic              fire_q;
  logic              key_event_q, key_event_d;
  logic [3:0]        arrow_mask;

  // Extended arrow codes map to one held bit each.
  always_comb begin
    arrow_mask = 4'b0000;
    case (key_data)
      8'h75:   arrow_mask = 4'b0001;
      8'h72:   arrow_mask = 4'b0010;
      8'h6B:   arrow_mask = 4'b0100;
      8'h74:   arrow_mask = 4'b1000;
      default: arrow_mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    cnt_d         = cnt_q;
    skip_d        = skip_q;
    seq_timeout_d = 1'b0;
    if (key_pressed) begin
      // A byte on the timeout cycle takes priority over abandoning.
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          case (key_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_SKIP;
              skip_d  = SKIP_INIT;
            end
            8'h29:   held_d[4] = 1'b1;
            default: ; // acks, errors and untracked keys
          endcase
        end
        S_EXT: begin
          if (key_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            // Fake shifts (E0 12 / E0 59) fall out here as untracked codes.
            held_d[3:0] = held_q[3:0] | arrow_mask;
            state_d     = S_IDLE;
          end
        end
        S_BRK: begin
          if (key_data == 8'h29) held_d[4] = 1'b0;
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          held_d[3:0] = held_q[3:0] & ~arrow_mask;
          state_d     = S_IDLE;
        end
        S_SKIP: begin
          skip_d = skip_q - SKIP_LAST;
          if (skip_q <= SKIP_LAST) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_MAX) begin
        state_d       = S_IDLE;
        skip_d        = '0;
        cnt_d         = '0;
        seq_timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output stage registered from the held bits: one more cycle after update.
  always_comb begin
    movement_d[1:0] = (held_q[0] & held_q[1]) ? 2'b00 : held_q[1:0];
    movement_d[3:2] = (held_q[2] & held_q[3]) ? 2'b00 : held_q[3:2];
    key_event_d     = (held_q != held_prev_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      held_q        <= '0;
      held_prev_q   <= '0;
      cnt_q         <= '0;
      skip_q        <= '0;
      seq_timeout_q <= 1'b0;
      movement_q    <= '0;
      fire_q        <= 1'b0;
      key_event_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      held_q        <= held_d;
      held_prev_q   <= held_q;
      cnt_q         <= cnt_d;
      skip_q        <= skip_d;
      seq_timeout_q <= seq_timeout_d;
      movement_q    <= movement_d;
      fire_q        <= held_q[4];
      key_event_q   <= key_event_d;
    end
  end

  assign movement    = movement_q;
  assign fire        = fire_q;
  assign key_event   = key_event_q;
  assign seq_timeout = seq_timeout_q;

endmodule
